// File: rtl/pop_subsys_pkg.sv
// Shared definitions for the stack pop subsystem: default widths, FSM states and pop op codes.
package pop_subsys_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD1  = 3'd2,
        ST_RD2  = 3'd3,
        ST_DONE = 3'd4
    } pop_state_e;

    typedef enum logic [1:0] {
        POP_PEEK = 2'd0,
        POP_ONE  = 2'd1,
        POP_TWO  = 2'd2,
        POP_ILL  = 2'd3
    } pop_op_e;

    // Number of stack entries an op must find present before it may run.
    function automatic logic [1:0] pop_need(input logic [1:0] cnt);
        return (cnt == 2'(POP_TWO)) ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/pop_subsys_stack_ptr.sv
// Stack pointer register: increment by one, decrement by 0..2, full/empty compares.
module pop_subsys_stack_ptr #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inc_i,
    input  logic            dec_i,
    input  logic [1:0]      dec_n_i,
    output logic [ADDR_W:0] sp_o,
    output logic            full_c,
    output logic            empty_c
);

    localparam int unsigned SP_W = ADDR_W + 1;
    localparam logic [SP_W-1:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};

    logic [SP_W-1:0] sp_q;
    logic [SP_W-1:0] sp_d;

    assign full_c  = (sp_q == DEPTH_V);
    assign empty_c = (sp_q == '0);
    assign sp_o    = sp_q;

    // Increment saturates at DEPTH; decrement never goes below zero.
    always_comb begin
        sp_d = sp_q;
        if (inc_i && !full_c) begin
            sp_d = sp_q + SP_W'(1);
        end else if (dec_i && (sp_q >= SP_W'(dec_n_i))) begin
            sp_d = sp_q - SP_W'(dec_n_i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

endmodule

// File: rtl/pop_subsys.sv
// Pop side of the stack datapath: reads one or two operands off the top of stack into A/B,
// owns the stack pointer and reports underflow/overflow, one start/done handshake per op.
module pop_subsys
    import pop_subsys_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        pop_cnt,
    input  logic              push_inc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] a_val,
    output logic [DATA_W-1:0] b_val,
    output logic [ADDR_W:0]   sp,
    output logic              busy,
    output logic              done,
    output logic              underflow,
    output logic              overflow
);

    localparam int unsigned SP_W = ADDR_W + 1;

    pop_state_e        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              re_q, re_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              unf_q, unf_d;
    logic              ovf_q, ovf_d;

    logic              sp_inc;
    logic              sp_dec;
    logic [1:0]        sp_dec_n;
    logic [SP_W-1:0]   sp_cur;
    logic              sp_full_c;
    logic              sp_empty_c;
    logic              start_bad_c;

    pop_subsys_stack_ptr #(
        .ADDR_W (ADDR_W)
    ) u_stack_ptr (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (sp_inc),
        .dec_i   (sp_dec),
        .dec_n_i (sp_dec_n),
        .sp_o    (sp_cur),
        .full_c  (sp_full_c),
        .empty_c (sp_empty_c)
    );

    // Empty stack fails every legal op; otherwise only a two-pop can be short.
    assign start_bad_c = (pop_cnt == 2'(POP_ILL)) || sp_empty_c ||
                         (sp_cur < SP_W'(pop_need(pop_cnt)));

    // Outputs are computed one state ahead so every port comes straight from a flop.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        addr_d   = addr_q;
        re_d     = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        unf_d    = unf_q;
        ovf_d    = ovf_q;
        sp_inc   = 1'b0;
        sp_dec   = 1'b0;
        sp_dec_n = 2'd0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (start_bad_c) begin
                        unf_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = pop_cnt;
                        unf_d   = 1'b0;
                        re_d    = 1'b1;
                        addr_d  = ADDR_W'(sp_cur - SP_W'(1));
                        state_d = ST_RD0;
                    end
                end else if (push_inc) begin
                    if (sp_full_c) begin
                        ovf_d = 1'b1;
                    end else begin
                        sp_inc = 1'b1;
                    end
                end
            end
            ST_RD0: begin
                state_d = ST_RD1;
                if (cnt_q == 2'(POP_TWO)) begin
                    re_d   = 1'b1;
                    addr_d = ADDR_W'(sp_cur - SP_W'(2));
                end
            end
            ST_RD1: begin
                a_d = mem_rdata;
                if (cnt_q == 2'(POP_TWO)) begin
                    state_d = ST_RD2;
                end else begin
                    done_d   = 1'b1;
                    sp_dec   = 1'b1;
                    sp_dec_n = cnt_q;
                    state_d  = ST_DONE;
                end
            end
            ST_RD2: begin
                b_d      = mem_rdata;
                done_d   = 1'b1;
                sp_dec   = 1'b1;
                sp_dec_n = 2'd2;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            a_q     <= '0;
            b_q     <= '0;
            addr_q  <= '0;
            re_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            unf_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            addr_q  <= addr_d;
            re_q    <= re_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            unf_q   <= unf_d;
            ovf_q   <= ovf_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_re    = re_q;
    assign a_val     = a_q;
    assign b_val     = b_q;
    assign sp        = sp_cur;
    assign busy      = busy_q;
    assign done      = done_q;
    assign underflow = unf_q;
    assign overflow  = ovf_q;

endmodule
